usb_dev_endpoint: RTL and testbench
===================================

# usb_dev_endpoint

Device-side responder for the host read/write protocol: consumes decoded token/data packets from the receive decoder, and maintains a 16-bit memory-page pointer set via OUT/endpoint-4. It performs a memory write (OUT/endpoint-4 data) or a memory read returned as an IN/endpoint-8 DATA packet. It answers each packet with ACK/NAK handshakes through the transmit encoder. It sits between the device's packet decoder/encoder pair and a 64-bit-wide local memory.

## Interface
- TIMEOUT, 255: cycles to wait for the DATA after a token, or for the host handshake after a DATA, before abandoning the transaction.
- DEV_ADDR, 7'b1010000: device address, transmission bit order.
- clk  in  1  single clock, all logic on posedge.
- rst_b  in  1  reset; synchronous, active-low.
- rx_valid  in  1  one-cycle pulse: decoded packet fields valid.
- rx_pid  in  8  PID byte, transmission order.
- rx_addr  in  7  token address field.
- rx_endp  in  4  token endpoint field.
- rx_data  in  64  DATA payload, transmission (LSB-first) order.
- rx_crc_ok  in  1  CRC5/CRC16 of the packet passed.
- tx_start  out  1  one-cycle pulse: send packet described by tx_pid/tx_data.
- tx_is_data  out  1  1 = DATA packet (PID + 64-bit payload), 0 = handshake (PID only).
- tx_pid  out  8  PID to send.
- tx_data  out  64  payload, transmission order.
- tx_done  in  1  one-cycle pulse: encoder finished the packet.
- mem_addr  out  16  memory page.
- mem_rd  out  1  read strobe; mem_rdata valid exactly one cycle later.
- mem_wr  out  1  write strobe, one cycle.
- mem_wdata  out  64  write data, natural bit order.
- mem_rdata  in  64  read data, natural bit order.
- addr_valid  out  1  page pointer loaded and not yet consumed.

## Operation
- PIDs, transmission order: OUT 8'b10000111, IN 8'b10010110, DATA0 8'b11000011, ACK 8'b01001011, NAK 8'b01011010. Endpoints: EP4 4'b0010, EP8 4'b0001.
- A token is accepted only if rx_valid, rx_crc_ok, rx_addr==DEV_ADDR, and (OUT,EP4) or (IN,EP8). Every other token is ignored silently.
- States:
  - IDLE: an accepted OUT token goes to WAIT_DATA. An accepted IN token goes to MEM_RD if addr_valid is set; otherwise it goes to SEND_HS with NAK.
  - WAIT_DATA: waits for rx_valid with rx_pid==DATA0.
    - CRC fail or wrong PID: SEND_HS with NAK.
    - CRC ok and addr_valid==0: mem_addr is loaded from the reversed payload bits [15:0], addr_valid is set, then SEND_HS with ACK.
    - CRC ok and addr_valid==1: mem_wr pulses with mem_wdata = reversed payload at mem_addr, addr_valid is cleared, then SEND_HS with ACK.
    - Timeout: return to IDLE, no response.
  - MEM_RD: pulses mem_rd for 1 cycle, then goes to MEM_WAIT.
  - MEM_WAIT: captures mem_rdata, then goes to SEND_DATA.
  - SEND_DATA: pulses tx_start with tx_is_data=1, tx_pid=DATA0 and tx_data = reversed captured word. Waits for tx_done, then goes to WAIT_ACK.
  - WAIT_ACK:
    - Valid ACK: clears addr_valid, returns to IDLE.
    - NAK, any other packet, or timeout: return to IDLE with addr_valid kept, so a host retry of IN re-reads the same page.
  - SEND_HS: pulses tx_start with tx_is_data=0, waits for tx_done, then returns to IDLE.
- rx_valid is ignored in MEM_RD, MEM_WAIT, SEND_DATA and SEND_HS.
- Payload bit reversal is a bitwise mirror: bit i maps to bit 63-i.

## Timing
- Reset (rst_b low at posedge) forces the following, effective at that edge, including mid-transaction:
  - state = IDLE, timeout counter = 0.
  - tx_start, tx_is_data, mem_rd, mem_wr, addr_valid = 0.
  - tx_pid = 8'b0, tx_data = 64'b0, mem_addr = 16'b0, mem_wdata = 64'b0.
- All outputs are registered.
- ACK/NAK response: tx_start asserts 1 cycle after the rx_valid that triggered it. mem_wr asserts in the same cycle as the ACK tx_start.
- IN response: mem_rd 1 cycle after the IN rx_valid; tx_start for DATA 3 cycles after it.
- tx_start is held 1 cycle only. tx_pid/tx_data/tx_is_data hold stable until tx_done.
- The timeout counter resets on entry to WAIT_DATA or WAIT_ACK. Expiry occurs on the cycle where the count reaches TIMEOUT, and the count saturates there.
- tx_done arriving in the same cycle as rx_valid: tx_done is honoured, rx_valid is dropped.

## Structure
- A shared package usb_pkg holds the PID, endpoint and DEV_ADDR-default constants and the state enum (IDLE, WAIT_DATA, MEM_RD, MEM_WAIT, SEND_DATA, WAIT_ACK, SEND_HS).
- Sub-module: the existing 64-bit `reverser`, instantiated twice (rx payload to memory order, memory word to tx order).

## Test plan
- Page set: OUT/EP4 token, then DATA0 whose reversed payload = 64'h0000_0000_0000_1234 -> mem_addr=16'h1234, addr_valid=1, ACK sent.
- Write: page set to 16'h0042, then OUT/EP4 + DATA0 carrying reversed 64'hDEAD_BEEF_0123_4567 -> one mem_wr at 16'h0042 with that data, ACK sent, addr_valid=0.
- Read: page set to 16'h0010, mem[0x10]=64'hA5A5_0000_FFFF_1111, then IN/EP8 -> DATA0 with tx_data = reversed word. Host ACK -> addr_valid=0. Host NAK and a second IN -> same data resent.
- Error paths:
  - DATA with rx_crc_ok=0 -> NAK, no mem_wr.
  - IN with addr_valid=0 -> NAK.
  - Token with rx_addr=7'h01 -> no tx_start.
- Timeout: OUT/EP4 token with no DATA for TIMEOUT cycles -> IDLE, no tx_start. A following valid sequence works normally.
- Reset: rst_b low during SEND_DATA (before tx_done) -> next cycle state=IDLE, addr_valid=0, all strobes 0.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared constants and state encoding for the USB device endpoint responder.
// PIDs, endpoints and the device address are in transmission bit order.
package usb_pkg;

    localparam logic [7:0] PID_OUT   = 8'b1000_0111;
    localparam logic [7:0] PID_IN    = 8'b1001_0110;
    localparam logic [7:0] PID_DATA0 = 8'b1100_0011;
    localparam logic [7:0] PID_ACK   = 8'b0100_1011;
    localparam logic [7:0] PID_NAK   = 8'b0101_1010;

    localparam logic [3:0] EP4 = 4'b0010;
    localparam logic [3:0] EP8 = 4'b0001;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b1010000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        MEM_RD    = 3'd2,
        MEM_WAIT  = 3'd3,
        SEND_DATA = 3'd4,
        WAIT_ACK  = 3'd5,
        SEND_HS   = 3'd6
    } state_e;

endpackage

// File: rtl/reverser.sv
// Bitwise mirror of a W-bit word: bit i of the input lands on bit W-1-i.
// Converts between USB transmission (LSB-first) order and natural order.
module reverser #(
    parameter int W = 64
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign dout[i] = din[W-1-i];
    end

endmodule

// File: rtl/usb_dev_endpoint.sv
// Device-side responder: OUT/EP4 sets the memory page or writes a word, IN/EP8
// reads the page back as a DATA0 packet; every packet is answered with ACK/NAK.
module usb_dev_endpoint
    import usb_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        rx_valid,
    input  logic [7:0]  rx_pid,
    input  logic [6:0]  rx_addr,
    input  logic [3:0]  rx_endp,
    input  logic [63:0] rx_data,
    input  logic        rx_crc_ok,
    output logic        tx_start,
    output logic        tx_is_data,
    output logic [7:0]  tx_pid,
    output logic [63:0] tx_data,
    input  logic        tx_done,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        addr_valid
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_start_q, tx_start_d;
    logic             tx_is_data_q, tx_is_data_d;
    logic [7:0]       tx_pid_q, tx_pid_d;
    logic [63:0]      tx_data_q, tx_data_d;
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic [63:0]      mem_wdata_q, mem_wdata_d;
    logic             addr_valid_q, addr_valid_d;

    logic [63:0] rx_rev;
    logic [63:0] rd_rev;
    logic        tok_ok;
    logic        out_tok;
    logic        in_tok;
    logic        cnt_exp;

    reverser #(.W(64)) u_rx_rev (.din(rx_data),   .dout(rx_rev));
    reverser #(.W(64)) u_rd_rev (.din(mem_rdata), .dout(rd_rev));

    always_comb begin
        tok_ok  = rx_valid && rx_crc_ok && (rx_addr == DEV_ADDR);
        out_tok = tok_ok && (rx_pid == PID_OUT) && (rx_endp == EP4);
        in_tok  = tok_ok && (rx_pid == PID_IN)  && (rx_endp == EP8);
        cnt_exp = (cnt_q == CNT_MAX);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_start_d   = 1'b0;
        tx_is_data_d = tx_is_data_q;
        tx_pid_d     = tx_pid_q;
        tx_data_d    = tx_data_q;
        mem_addr_d   = mem_addr_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        addr_valid_d = addr_valid_q;

        case (state_q)
            IDLE: begin
                if (out_tok) begin
                    state_d = WAIT_DATA;
                    cnt_d   = '0;
                end else if (in_tok) begin
                    if (addr_valid_q) begin
                        state_d  = MEM_RD;
                        mem_rd_d = 1'b1;
                    end else begin
                        state_d      = SEND_HS;
                        tx_start_d   = 1'b1;
                        tx_is_data_d = 1'b0;
                        tx_pid_d     = PID_NAK;
                    end
                end
            end

            WAIT_DATA: begin
                if (rx_valid) begin
                    // Any packet here ends the transaction; only a good DATA0 earns an ACK.
                    state_d      = SEND_HS;
                    tx_start_d   = 1'b1;
                    tx_is_data_d = 1'b0;
                    tx_pid_d     = PID_NAK;
                    if (rx_crc_ok && (rx_pid == PID_DATA0)) begin
                        tx_pid_d = PID_ACK;
                        if (!addr_valid_q) begin
                            mem_addr_d   = rx_rev[15:0];
                            addr_valid_d = 1'b1;
                        end else begin
                            mem_wr_d     = 1'b1;
                            mem_wdata_d  = rx_rev;
                            addr_valid_d = 1'b0;
                        end
                    end
                end else if (cnt_exp) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            MEM_RD: state_d = MEM_WAIT;

            MEM_WAIT: begin
                state_d      = SEND_DATA;
                tx_start_d   = 1'b1;
                tx_is_data_d = 1'b1;
                tx_pid_d     = PID_DATA0;
                tx_data_d    = rd_rev;
            end

            SEND_DATA: begin
                if (tx_done) begin
                    state_d = WAIT_ACK;
                    cnt_d   = '0;
                end
            end

            WAIT_ACK: begin
                // Only a host ACK consumes the page; anything else leaves it for a retry.
                if (rx_valid) begin
                    state_d = IDLE;
                    if (rx_pid == PID_ACK) begin
                        addr_valid_d = 1'b0;
                    end
                end else if (cnt_exp) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SEND_HS: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_is_data_q <= 1'b0;
            tx_pid_q     <= 8'b0;
            tx_data_q    <= 64'b0;
            mem_addr_q   <= 16'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= 64'b0;
            addr_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_start_q   <= tx_start_d;
            tx_is_data_q <= tx_is_data_d;
            tx_pid_q     <= tx_pid_d;
            tx_data_q    <= tx_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_wdata_q  <= mem_wdata_d;
            addr_valid_q <= addr_valid_d;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_is_data = tx_is_data_q;
    assign tx_pid     = tx_pid_q;
    assign tx_data    = tx_data_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wdata  = mem_wdata_q;
    assign addr_valid = addr_valid_q;

endmodule

// File: tb/tb_usb_dev_endpoint.sv
// Bench for usb_dev_endpoint: host transactions drive a transaction-level model that
// predicts each strobe and packet by cycle; a compare process checks them every cycle.
module tb_usb_dev_endpoint;

    localparam int         TIMEOUT = 255;
    localparam logic [6:0] DEV     = 7'b1010000;
    localparam logic [7:0] P_OUT   = 8'b10000111;
    localparam logic [7:0] P_IN    = 8'b10010110;
    localparam logic [7:0] P_DATA0 = 8'b11000011;
    localparam logic [7:0] P_ACK   = 8'b01001011;
    localparam logic [7:0] P_NAK   = 8'b01011010;
    localparam logic [3:0] E4      = 4'b0010;
    localparam logic [3:0] E8      = 4'b0001;

    logic        clk;
    logic        rst_b;
    logic        rx_valid;
    logic [7:0]  rx_pid;
    logic [6:0]  rx_addr;
    logic [3:0]  rx_endp;
    logic [63:0] rx_data;
    logic        rx_crc_ok;
    logic        tx_start;
    logic        tx_is_data;
    logic [7:0]  tx_pid;
    logic [63:0] tx_data;
    logic        tx_done;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        addr_valid;

    usb_dev_endpoint dut (
        .clk(clk), .rst_b(rst_b),
        .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp),
        .rx_data(rx_data), .rx_crc_ok(rx_crc_ok),
        .tx_start(tx_start), .tx_is_data(tx_is_data), .tx_pid(tx_pid), .tx_data(tx_data),
        .tx_done(tx_done),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .addr_valid(addr_valid)
    );

    typedef struct {
        int          cyc;
        logic [7:0]  pid;
        logic        is_data;
        logic [63:0] data;
    } tx_ev_t;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [63:0] data;
    } mem_ev_t;

    tx_ev_t  exp_tx[$];
    mem_ev_t exp_wr[$];
    mem_ev_t exp_rd[$];
    tx_ev_t  tev;
    mem_ev_t mev;

    // Host-visible model state and the memory contents the host has written.
    logic        m_av;
    logic [15:0] m_page;
    logic [63:0] m_mem [logic [15:0]];
    logic [63:0] mem_env [logic [15:0]];

    int cyc;
    int n_cmp;
    int n_err;
    bit chk_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63-i] = x[i];
        return r;
    endfunction

    function automatic logic [63:0] m_rd(input logic [15:0] a);
        return m_mem.exists(a) ? m_mem[a] : 64'h0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Encoder stand-in: finishes each packet 2..5 cycles after tx_start.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat ($urandom_range(2, 5)) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Memory stand-in: write on mem_wr, read data valid the cycle after mem_rd.
    initial begin
        logic        rd, wr;
        logic [15:0] a;
        logic [63:0] d;
        mem_rdata = 64'h0;
        forever begin
            @(negedge clk);
            rd = mem_rd; wr = mem_wr; a = mem_addr; d = mem_wdata;
            @(posedge clk);
            #1;
            if (wr) mem_env[a] = d;
            if (rd) mem_rdata = mem_env.exists(a) ? mem_env[a] : 64'h0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin : cmp
            logic e;
            e = (exp_tx.size() > 0) && (exp_tx[0].cyc == cyc);
            chk("tx_start", tx_start, e);
            if (e) begin
                tev = exp_tx.pop_front();
                if (tx_start) begin
                    chk("tx_pid", tx_pid, tev.pid);
                    chk("tx_is_data", tx_is_data, tev.is_data);
                    if (tev.is_data) chk("tx_data", tx_data, tev.data);
                end
            end
            e = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
            chk("mem_wr", mem_wr, e);
            if (e) begin
                mev = exp_wr.pop_front();
                if (mem_wr) begin
                    chk("wr_addr", mem_addr, mev.addr);
                    chk("wr_data", mem_wdata, mev.data);
                end
            end
            e = (exp_rd.size() > 0) && (exp_rd[0].cyc == cyc);
            chk("mem_rd", mem_rd, e);
            if (e) begin
                mev = exp_rd.pop_front();
                if (mem_rd) chk("rd_addr", mem_addr, mev.addr);
            end
        end
    end

    task automatic send(input logic [7:0] pid, input logic [6:0] a, input logic [3:0] ep,
                        input logic [63:0] d, input logic crc, output int n);
        @(posedge clk);
        #1;
        rx_valid = 1'b1; rx_pid = pid; rx_addr = a; rx_endp = ep; rx_data = d; rx_crc_ok = crc;
        n = cyc;
        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
        rx_pid    = 8'($urandom);
        rx_addr   = 7'($urandom);
        rx_endp   = 4'($urandom);
        rx_data   = {$urandom, $urandom};
        rx_crc_ok = 1'($urandom);
    endtask

    task automatic exp_hs(input int n, input logic [7:0] pid);
        tx_ev_t t;
        t.cyc = n + 1; t.pid = pid; t.is_data = 1'b0; t.data = 64'h0;
        exp_tx.push_back(t);
    endtask

    task automatic quiet(input int k);
        repeat (k) @(posedge clk);
    endtask

    task automatic check_state();
        @(negedge clk);
        chk("addr_valid", addr_valid, m_av);
        if (m_av) chk("page", mem_addr, m_page);
    endtask

    // kind 0: good DATA0, 1: DATA0 with bad CRC, 2: wrong PID in the data phase.
    task automatic do_out(input logic [63:0] nat, input int kind);
        int      n;
        mem_ev_t w;
        send(P_OUT, DEV, E4, {$urandom, $urandom}, 1'b1, n);
        quiet($urandom_range(0, 3));
        case (kind)
            0:       send(P_DATA0, 7'($urandom), 4'($urandom), rev64(nat), 1'b1, n);
            1:       send(P_DATA0, 7'($urandom), 4'($urandom), rev64(nat), 1'b0, n);
            default: send(P_IN, DEV, E8, rev64(nat), 1'b1, n);
        endcase
        if (kind != 0) begin
            exp_hs(n, P_NAK);
        end else if (!m_av) begin
            m_page = nat[15:0];
            m_av   = 1'b1;
            exp_hs(n, P_ACK);
        end else begin
            w.cyc = n + 1; w.addr = m_page; w.data = nat;
            exp_wr.push_back(w);
            m_mem[m_page] = nat;
            m_av = 1'b0;
            exp_hs(n, P_ACK);
        end
        quiet(12);
    endtask

    // resp 0: host ACK, 1: host NAK, 2: unrelated packet, 3: host silent.
    task automatic do_in(input int resp);
        int      n;
        bit      seen;
        tx_ev_t  t;
        mem_ev_t r;
        send(P_IN, DEV, E8, {$urandom, $urandom}, 1'b1, n);
        if (!m_av) begin
            exp_hs(n, P_NAK);
            quiet(12);
            return;
        end
        r.cyc = n + 1; r.addr = m_page; r.data = 64'h0;
        exp_rd.push_back(r);
        t.cyc = n + 3; t.pid = P_DATA0; t.is_data = 1'b1; t.data = rev64(m_rd(m_page));
        exp_tx.push_back(t);
        seen = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("in_data_done", seen, 1'b1);
        quiet($urandom_range(0, 3));
        case (resp)
            0: begin
                send(P_ACK, 7'h0, 4'h0, 64'h0, 1'b1, n);
                m_av = 1'b0;
            end
            1: send(P_NAK, 7'h0, 4'h0, 64'h0, 1'b1, n);
            2: send(P_OUT, DEV, E4, 64'h0, 1'b1, n);
            default: quiet(TIMEOUT + 10);
        endcase
        quiet(6);
    endtask

    task automatic bad_token(input int kind);
        int n;
        case (kind)
            0: send(P_OUT, 7'h01, E4, 64'h0, 1'b1, n);
            1: send(P_IN, DEV, E4, 64'h0, 1'b1, n);
            2: send(P_OUT, DEV, E4, 64'h0, 1'b0, n);
            3: send(P_ACK, DEV, E8, 64'h0, 1'b1, n);
            default: send(P_IN, 7'h01, E8, 64'h0, 1'b1, n);
        endcase
        quiet(6);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tx_start"}, tx_start, 1'b0);
        chk({tag, "_tx_is_data"}, tx_is_data, 1'b0);
        chk({tag, "_mem_rd"}, mem_rd, 1'b0);
        chk({tag, "_mem_wr"}, mem_wr, 1'b0);
        chk({tag, "_addr_valid"}, addr_valid, 1'b0);
        chk({tag, "_tx_pid"}, tx_pid, 8'h0);
        chk({tag, "_tx_data"}, tx_data, 64'h0);
        chk({tag, "_mem_addr"}, mem_addr, 16'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'h0);
    endtask

    initial begin
        int n;
        int r;
        tx_ev_t  t;
        mem_ev_t rd;
        cyc = 0; n_cmp = 0; n_err = 0; chk_en = 1'b0;
        m_av = 1'b0; m_page = 16'h0;
        rst_b = 1'b0; rx_valid = 1'b0; rx_pid = 8'h0; rx_addr = 7'h0; rx_endp = 4'h0;
        rx_data = 64'h0; rx_crc_ok = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_b = 1'b1;
        chk_en = 1'b1;

        chk("pin_rev_1234", rev64(64'h0000_0000_0000_1234), 64'h2C48_0000_0000_0000);
        chk("pin_rev_a5a5", rev64(64'hA5A5_0000_FFFF_1111), 64'h8888_FFFF_0000_A5A5);

        // Page set
        do_out(64'h0000_0000_0000_1234, 0);
        @(negedge clk);
        chk("page_1234", mem_addr, 16'h1234);
        chk("page_1234_valid", addr_valid, 1'b1);

        // Write: first consume the 0x1234 page, then set 0x0042 and write
        do_out(64'h0, 0);
        do_out(64'h0000_0000_0000_0042, 0);
        do_out(64'hDEAD_BEEF_0123_4567, 0);
        @(negedge clk);
        chk("write_0042", mem_env.exists(16'h0042) ? mem_env[16'h0042] : 64'h0,
            64'hDEAD_BEEF_0123_4567);
        chk("write_clears_valid", addr_valid, 1'b0);

        // Read: host NAK then retry with ACK
        do_out(64'h0000_0000_0000_0010, 0);
        do_out(64'hA5A5_0000_FFFF_1111, 0);
        do_out(64'h0000_0000_0000_0010, 0);
        do_in(1);
        check_state();
        chk("nak_keeps_valid", addr_valid, 1'b1);
        do_in(0);
        check_state();
        chk("ack_clears_valid", addr_valid, 1'b0);

        // Error paths
        do_out(64'h0000_0000_0000_0077, 1);
        check_state();
        do_out(64'h0000_0000_0000_0077, 2);
        do_in(0);
        bad_token(0);
        bad_token(4);
        check_state();

        // Timeout in WAIT_DATA: a late DATA0 must go unanswered
        send(P_OUT, DEV, E4, 64'h0, 1'b1, n);
        quiet(TIMEOUT + 5);
        send(P_DATA0, DEV, E4, rev64(64'h5555), 1'b1, n);
        quiet(12);
        check_state();
        do_out(64'h0000_0000_0000_0321, 0);
        check_state();

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 15);
            if (r < 6)       do_out({$urandom, $urandom}, ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 2));
            else if (r < 11) do_in(($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2));
            else if (r < 15) bad_token($urandom_range(0, 4));
            else             do_in(3);
            check_state();
        end

        // Reset while the DATA packet is still being sent
        if (!m_av) do_out({$urandom, $urandom}, 0);
        send(P_IN, DEV, E8, 64'h0, 1'b1, n);
        rd.cyc = n + 1; rd.addr = m_page; rd.data = 64'h0;
        exp_rd.push_back(rd);
        t.cyc = n + 3; t.pid = P_DATA0; t.is_data = 1'b1; t.data = rev64(m_rd(m_page));
        exp_tx.push_back(t);
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("midreset");
        rst_b = 1'b1;
        m_av = 1'b0;
        m_page = 16'h0;
        quiet(12);
        do_in(0);
        do_out(64'h0000_0000_0000_0abc, 0);
        check_state();

        quiet(20);
        chk("exp_tx_drained", exp_tx.size(), 0);
        chk("exp_wr_drained", exp_wr.size(), 0);
        chk("exp_rd_drained", exp_rd.size(), 0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
